fetch_unit: RTL and testbench

Instruction-fetch stage wrapped around `ProgramCounter`. It consumes `PCResult`, issues one instruction-memory request at a time, and returns `PCNext` so the counter holds or advances. Fetched words are buffered through a 2-entry output queue into a valid/ready interface toward decode. Branch/jump redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch stage      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INCREMENT        = 4;
  localparam int          DEFAULT_INSTR_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_queue : 2-entry FIFO of {instr, pc}; flush beats push     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int BITS_SIZE   = 32,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  localparam int ENTRY_W    = INSTR_WIDTH + BITS_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head
);

  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] e0_q, e0_d;
  logic [ENTRY_W-1:0] e1_q, e1_d;
  logic               do_pop;

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    do_pop  = pop && (count_q != 2'd0);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, do_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_d    = push_data;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            e1_d    = push_data;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count = count_q;
  assign head  = e0_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_unit : single-outstanding instruction fetch with redirect |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BITS_SIZE   = 32,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [BITS_SIZE-1:0]   PCResult,
  output logic [BITS_SIZE-1:0]   PCNext,
  input  logic                   Redirect,
  input  logic [BITS_SIZE-1:0]   RedirectTarget,
  output logic                   IMemReq,
  output logic [BITS_SIZE-1:0]   IMemAddr,
  input  logic                   IMemGnt,
  input  logic                   IMemRValid,
  input  logic [INSTR_WIDTH-1:0] IMemRData,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [BITS_SIZE-1:0]   InstrPC,
  input  logic                   InstrReady
);

  localparam int ENTRY_W = INSTR_WIDTH + BITS_SIZE;

  fetch_state_t         state_q, state_d;
  logic [BITS_SIZE-1:0] pending_pc_q, pending_pc_d;
  logic [1:0]           q_count;
  logic [ENTRY_W-1:0]   q_head;
  logic                 grant;
  logic                 push;
  logic                 pop;
  logic [BITS_SIZE-1:0] redirect_pc;

  always_comb begin
    redirect_pc = RedirectTarget & ~BITS_SIZE'(3);
    IMemReq     = !Reset && !Redirect && (state_q == S_REQ) && (q_count < 2'd2);
    IMemAddr    = PCResult;
    grant       = IMemReq && IMemGnt;
    push        = !Reset && !Redirect && (state_q == S_WAIT) && IMemRValid;
    pop         = InstrValid && InstrReady;

    if (Reset) begin
      PCNext = PCResult;
    end else if (Redirect) begin
      PCNext = redirect_pc;
    end else if (grant) begin
      PCNext = PCResult + BITS_SIZE'(PC_INCREMENT);
    end else begin
      PCNext = PCResult;
    end
  end

  // A response arriving with a redirect closes the outstanding request,
  // so there is nothing left to drop and the FSM returns to S_REQ.
  always_comb begin
    state_d      = state_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      S_REQ: begin
        if (grant) begin
          state_d      = S_WAIT;
          pending_pc_d = PCResult;
        end
      end
      S_WAIT: begin
        if (IMemRValid) begin
          state_d = S_REQ;
        end else if (Redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (IMemRValid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_REQ;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  fetch_queue #(
    .BITS_SIZE   (BITS_SIZE),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_queue (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_data ({IMemRData, pending_pc_q}),
    .pop       (pop),
    .flush     (Redirect),
    .count     (q_count),
    .head      (q_head)
  );

  assign InstrValid = (q_count != 2'd0);
  assign Instr      = q_head[ENTRY_W-1:BITS_SIZE];
  assign InstrPC    = q_head[BITS_SIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fetch_unit : directed bench with PC register and memory model|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic [31:0] PCNext;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady;

  int n_vec     = 0;
  int n_miscmp  = 0;
  int lat       = 1;

  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] pc_q;

  fetch_unit #(.BITS_SIZE(32), .INSTR_WIDTH(32)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .PCResult       (PCResult),
    .PCNext         (PCNext),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemGnt        (IMemGnt),
    .IMemRValid     (IMemRValid),
    .IMemRData      (IMemRData),
    .InstrValid     (InstrValid),
    .Instr          (Instr),
    .InstrPC        (InstrPC),
    .InstrReady     (InstrReady)
  );

  always #5 Clk = ~Clk;

  // Instruction word for an address: 0x11 * (word index within 1 KiB + 1)
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] idx;
    idx = {24'd0, a[9:2]} + 32'd1;
    return idx * 32'h11;
  endfunction

  always @(posedge Clk) begin
    if (Reset) pc_q <= 32'd0;
    else       pc_q <= PCNext;
  end
  assign PCResult = pc_q;

  always @(posedge Clk) begin
    if (Reset) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 32'd0;
    end else begin
      if (IMemRValid)    mem_busy <= 1'b0;
      else if (mem_busy) mem_cnt  <= mem_cnt - 1;
      if (IMemReq && IMemGnt) begin
        mem_busy <= 1'b1;
        mem_cnt  <= lat - 1;
        mem_addr <= IMemAddr;
      end
    end
  end
  assign IMemRValid = mem_busy && (mem_cnt == 0);
  assign IMemRData  = mem_data(mem_addr);

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    Redirect = 1'b0;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  // Ends at the negedge of the first cycle with InstrValid high.
  task automatic wait_instr(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      sample();
      if (InstrValid) found = 1'b1;
      else next_cycle();
    end
    if (!found) check_value("wait_instr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    Reset          = 1'b1;
    Redirect       = 1'b0;
    RedirectTarget = 32'd0;
    IMemGnt        = 1'b1;
    InstrReady     = 1'b1;

    // Reset values
    sample();
    check_value("rst_req",    IMemReq,    0);
    check_value("rst_valid",  InstrValid, 0);
    check_value("rst_instr",  Instr,      0);
    check_value("rst_ipc",    InstrPC,    0);
    check_value("rst_pcnext", PCNext,     PCResult);
    next_cycle();

    // Streaming with 1-cycle memory
    lat = 1; InstrReady = 1'b1; IMemGnt = 1'b1;
    do_reset();
    sample();
    check_value("s1_c1_req",    IMemReq,    1);
    check_value("s1_c1_addr",   IMemAddr,   32'h0);
    check_value("s1_c1_pcnext", PCNext,     32'h4);
    check_value("s1_c1_valid",  InstrValid, 0);
    next_cycle(); sample();
    check_value("s1_c2_req",    IMemReq,    0);
    check_value("s1_c2_pcnext", PCNext,     32'h4);
    check_value("s1_c2_valid",  InstrValid, 0);
    next_cycle(); sample();
    check_value("s1_c3_valid",  InstrValid, 1);
    check_value("s1_c3_ipc",    InstrPC,    32'h0);
    check_value("s1_c3_instr",  Instr,      32'h11);
    check_value("s1_c3_addr",   IMemAddr,   32'h4);
    next_cycle(); sample();
    check_value("s1_c4_valid",  InstrValid, 0);
    next_cycle(); sample();
    check_value("s1_c5_ipc",    InstrPC,    32'h4);
    check_value("s1_c5_instr",  Instr,      32'h22);
    check_value("s1_c5_addr",   IMemAddr,   32'h8);
    next_cycle(); next_cycle(); sample();
    check_value("s1_c7_ipc",    InstrPC,    32'h8);
    check_value("s1_c7_instr",  Instr,      32'h33);
    check_value("s1_c7_addr",   IMemAddr,   32'hC);
    next_cycle();

    // Backpressure: queue fills with PC 0 and 4, fetch stalls at 8
    lat = 1; InstrReady = 1'b0;
    do_reset();
    repeat (10) @(posedge Clk);
    sample();
    check_value("s2_stall_req",   IMemReq,    0);
    check_value("s2_stall_pc",    PCResult,   32'h8);
    check_value("s2_stall_valid", InstrValid, 1);
    check_value("s2_stall_ipc",   InstrPC,    32'h0);
    next_cycle();
    InstrReady = 1'b1;
    sample();
    check_value("s2_rel_ipc0",   InstrPC,  32'h0);
    check_value("s2_rel_instr0", Instr,    32'h11);
    next_cycle(); sample();
    check_value("s2_rel_ipc1",   InstrPC,  32'h4);
    check_value("s2_rel_instr1", Instr,    32'h22);
    check_value("s2_rel_req",    IMemReq,  1);
    check_value("s2_rel_addr",   IMemAddr, 32'h8);
    next_cycle();
    wait_instr(10);
    check_value("s2_resume_ipc",   InstrPC, 32'h8);
    check_value("s2_resume_instr", Instr,   32'h33);
    next_cycle();

    // Redirect while waiting on PC 8; its response lands two cycles later
    lat = 1; InstrReady = 1'b1;
    do_reset();
    next_cycle(); next_cycle(); next_cycle();
    lat = 3;
    next_cycle();
    InstrReady = 1'b0;
    next_cycle();
    Redirect = 1'b1; RedirectTarget = 32'h103;
    sample();
    check_value("s3_rd_pcnext", PCNext,     32'h100);
    check_value("s3_rd_req",    IMemReq,    0);
    check_value("s3_rd_valid",  InstrValid, 1);
    next_cycle();
    Redirect = 1'b0; InstrReady = 1'b1;
    sample();
    check_value("s3_flush_valid", InstrValid, 0);
    check_value("s3_drop_req",    IMemReq,    0);
    next_cycle(); sample();
    check_value("s3_drop_req2",   IMemReq,    0);
    next_cycle(); sample();
    check_value("s3_new_req",     IMemReq,    1);
    check_value("s3_new_addr",    IMemAddr,   32'h100);
    check_value("s3_new_valid",   InstrValid, 0);
    next_cycle();
    wait_instr(10);
    check_value("s3_ipc",   InstrPC, 32'h100);
    check_value("s3_instr", Instr,   32'h451);
    next_cycle();

    // Redirect coinciding with the response
    lat = 1; InstrReady = 1'b1;
    do_reset();
    next_cycle();
    Redirect = 1'b1; RedirectTarget = 32'h200;
    sample();
    check_value("s4_rvalid",  IMemRValid, 1);
    check_value("s4_pcnext",  PCNext,     32'h200);
    next_cycle();
    Redirect = 1'b0;
    sample();
    check_value("s4_valid",   InstrValid, 0);
    check_value("s4_req",     IMemReq,    1);
    check_value("s4_addr",    IMemAddr,   32'h200);
    next_cycle();
    wait_instr(10);
    check_value("s4_ipc",   InstrPC, 32'h200);
    check_value("s4_instr", Instr,   32'h891);
    next_cycle();

    // PC wrap at top of address space; target low bits are masked
    lat = 1; InstrReady = 1'b1;
    do_reset();
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFF;
    sample();
    check_value("s5_rd_req",    IMemReq, 0);
    check_value("s5_rd_pcnext", PCNext,  32'hFFFF_FFFC);
    next_cycle();
    Redirect = 1'b0;
    sample();
    check_value("s5_req",    IMemReq,  1);
    check_value("s5_addr",   IMemAddr, 32'hFFFF_FFFC);
    check_value("s5_wrap",   PCNext,   32'h0);
    next_cycle();
    wait_instr(10);
    check_value("s5_ipc",   InstrPC, 32'hFFFF_FFFC);
    check_value("s5_instr", Instr,   32'h1100);
    next_cycle();

    // Grant withheld, then reset mid-wait with one queued entry
    lat = 1; InstrReady = 1'b1; IMemGnt = 1'b0;
    do_reset();
    sample();
    check_value("s6_nognt_req",    IMemReq, 1);
    check_value("s6_nognt_pcnext", PCNext,  32'h0);
    next_cycle();
    IMemGnt = 1'b1; InstrReady = 1'b0;
    sample();
    check_value("s6_gnt_pcnext", PCNext, 32'h4);
    next_cycle(); next_cycle();
    sample();
    check_value("s6_q1_ipc", InstrPC, 32'h0);
    next_cycle();
    Reset = 1'b1;
    sample();
    check_value("s6_rst_req",    IMemReq, 0);
    check_value("s6_rst_pcnext", PCNext,  PCResult);
    next_cycle();
    Reset = 1'b0;
    sample();
    check_value("s6_post_valid", InstrValid, 0);
    check_value("s6_post_instr", Instr,      0);
    check_value("s6_post_ipc",   InstrPC,    0);
    check_value("s6_post_req",   IMemReq,    1);
    check_value("s6_post_addr",  IMemAddr,   32'h0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
